trng_sampler_ctrl: RTL

Sequencing controller for the ring-oscillator entropy combiner. It gates the RO array enable and waits a warm-up interval. It flushes the registered XOR tree, then decimates the combiner output into WORD_WIDTH-bit words. Each raw sample passes a repetition-count health test, and words are delivered to the consumer over a valid/ready handshake.

---
 rtl/trng_pkg.sv | 28 ++
 rtl/trng_health_rct.sv | 56 +++++
 rtl/trng_sampler_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types, parameter defaults and width helper for the TRNG sampler
`ifndef LOG_NUM_OF_RO
`define LOG_NUM_OF_RO 2
`endif

package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_FLUSH,
        ST_COLLECT,
        ST_HOLD,
        ST_FAIL
    } trng_state_e;

    localparam int DEF_WORD_WIDTH    = 32;
    localparam int DEF_WARMUP_CYCLES = 1024;
    localparam int DEF_PIPE_LAT      = `LOG_NUM_OF_RO + 1;
    localparam int DEF_SAMPLE_DIV    = 4;
    localparam int DEF_REP_LIMIT     = 16;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trng_health_rct.sv
// rtl/trng_health_rct.sv - repetition-count health test over decimated raw samples
module trng_health_rct
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic sample_en_i,
    input  logic bit_i,
    output logic fail_o
);

    localparam int RUN_W = cnt_width(REP_LIMIT);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(REP_LIMIT);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             prev_q, prev_d;
    logic             seen_q, seen_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            run_q  <= '0;
            prev_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
            seen_q <= seen_d;
        end
    end

    // fail_o is combinational so the controller can leave on the offending tick itself.
    always_comb begin
        run_d  = run_q;
        prev_d = prev_q;
        seen_d = seen_q;
        fail_o = 1'b0;
        if (clear_i) begin
            run_d  = '0;
            seen_d = 1'b0;
        end else if (sample_en_i) begin
            prev_d = bit_i;
            seen_d = 1'b1;
            if (!seen_q || (bit_i != prev_q)) begin
                run_d = RUN_ONE;
            end else if (run_q != RUN_LIMIT) begin
                run_d = run_q + RUN_ONE;
            end
            fail_o = (run_d == RUN_LIMIT);
        end
    end

endmodule

// File: rtl/trng_sampler_ctrl.sv
// rtl/trng_sampler_ctrl.sv - RO enable sequencing, decimation into words, health gating and word handshake
module trng_sampler_ctrl
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int PIPE_LAT      = DEF_PIPE_LAT,
    parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  fail_clear_i,
    input  logic                  raw_bit_i,
    output logic                  ro_enable_o,
    output logic [WORD_WIDTH-1:0] word_data_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic                  busy_o,
    output logic                  health_fail_o
);

    localparam int CYC_MAX = (WARMUP_CYCLES > PIPE_LAT) ? WARMUP_CYCLES - 1 : PIPE_LAT - 1;
    localparam int CYC_W   = cnt_width(CYC_MAX);
    localparam int DIV_W   = cnt_width(SAMPLE_DIV - 1);
    localparam int SMP_W   = cnt_width(WORD_WIDTH - 1);

    localparam logic [CYC_W-1:0] WARM_LAST  = CYC_W'(WARMUP_CYCLES - 1);
    localparam logic [CYC_W-1:0] FLUSH_LAST = CYC_W'(PIPE_LAT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'(WORD_WIDTH - 1);

    trng_state_e           state_q, state_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [SMP_W-1:0]      smp_q, smp_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  ro_en_q, ro_en_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  fail_q, fail_d;

    logic tick;
    logic sample_en;
    logic rct_clear;
    logic rct_fail;
    logic handshake;

    assign tick      = (div_q == DIV_LAST);
    assign sample_en = (state_q == ST_COLLECT) && tick && !stop_i;
    assign rct_clear = (state_q == ST_FLUSH) && (cyc_q == FLUSH_LAST) && !stop_i;
    assign handshake = (state_q == ST_HOLD) && valid_q && word_ready_i;

    trng_health_rct #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rct (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .clear_i     (rct_clear),
        .sample_en_i (sample_en),
        .bit_i       (raw_bit_i),
        .fail_o      (rct_fail)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            div_q       <= '0;
            smp_q       <= '0;
            shreg_q     <= '0;
            word_q      <= '0;
            stop_pend_q <= 1'b0;
            ro_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            div_q       <= div_d;
            smp_q       <= smp_d;
            shreg_q     <= shreg_d;
            word_q      <= word_d;
            stop_pend_q <= stop_pend_d;
            ro_en_q     <= ro_en_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        div_d       = div_q;
        smp_d       = smp_q;
        shreg_d     = shreg_q;
        word_d      = word_q;
        stop_pend_d = stop_pend_q;
        unique case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start_i && !stop_i) begin
                    state_d = ST_WARMUP;
                    cyc_d   = '0;
                end
            end
            ST_WARMUP: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (cyc_q == WARM_LAST) begin
                    state_d = ST_FLUSH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (cyc_q == FLUSH_LAST) begin
                    state_d = ST_COLLECT;
                    cyc_d   = '0;
                    div_d   = '0;
                    smp_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_COLLECT: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (!tick) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d   = '0;
                    shreg_d = {shreg_q[WORD_WIDTH-2:0], raw_bit_i};
                    // A failing sample outranks completing the word it would finish.
                    if (rct_fail) begin
                        state_d = ST_FAIL;
                    end else if (smp_q == SMP_LAST) begin
                        state_d = ST_HOLD;
                        smp_d   = '0;
                        word_d  = shreg_d;
                    end else begin
                        smp_d = smp_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (handshake) begin
                    if (stop_pend_q || stop_i) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = ST_COLLECT;
                        div_d   = '0;
                        smp_d   = '0;
                    end
                end
            end
            ST_FAIL: begin
                if (fail_clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ro_en_d = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        fail_d  = 1'b0;
        unique case (state_d)
            ST_WARMUP, ST_FLUSH, ST_COLLECT: begin
                ro_en_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_HOLD: begin
                ro_en_d = 1'b1;
                busy_d  = 1'b1;
                valid_d = 1'b1;
            end
            ST_FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
                ro_en_d = 1'b0;
            end
        endcase
    end

    assign ro_enable_o   = ro_en_q;
    assign word_data_o   = word_q;
    assign word_valid_o  = valid_q;
    assign busy_o        = busy_q;
    assign health_fail_o = fail_q;

endmodule
